// File: rtl/mq_pkg.sv
// Shared definitions for the MQ coder front end: default context width,
// JPEG2000 context indices and the packed CX/D buffer entry.
package mq_pkg;

  localparam int MQ_CX_W = 5;

  typedef enum logic [MQ_CX_W-1:0] {
    CX_ZC0 = 5'd0,  CX_ZC1 = 5'd1,  CX_ZC2 = 5'd2,  CX_ZC3 = 5'd3,
    CX_ZC4 = 5'd4,  CX_ZC5 = 5'd5,  CX_ZC6 = 5'd6,  CX_ZC7 = 5'd7,
    CX_ZC8 = 5'd8,  CX_SC0 = 5'd9,  CX_SC1 = 5'd10, CX_SC2 = 5'd11,
    CX_SC3 = 5'd12, CX_SC4 = 5'd13, CX_MR0 = 5'd14, CX_MR1 = 5'd15,
    CX_MR2 = 5'd16, CX_RL  = 5'd17, CX_UNI = 5'd18
  } mq_cx_e;

  typedef struct packed {
    logic               last;
    logic               d;
    logic [MQ_CX_W-1:0] cx;
  } mq_entry_t;

endpackage

// File: rtl/mq_cxd_fifo.sv
// CX/D buffer between the bit-plane coder and the MQ coder: FWFT head,
// pop on update_flag, one codeblock per drain via the in-band last tag.
module mq_cxd_fifo
  import mq_pkg::*;
#(
  parameter int CX_W     = MQ_CX_W,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_d,
  input  logic [CX_W-1:0]            in_cx,
  input  logic                       in_last,
  output logic                       out_valid,
  output logic                       out_d,
  output logic [CX_W-1:0]            out_cx,
  input  logic                       update_flag,
  output logic                       flush_req,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       err_underflow,
  output logic                       err_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int EW = CX_W + 2;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic          pend_q, pend_d;
  logic          flush_q, flush_d;
  logic          af_q, af_d;
  logic          eu_q, eu_d;
  logic          eo_q, eo_d;

  logic          full, empty, push, pop, head_last;
  logic [EW-1:0] head;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign head      = mem_q[rp_q];
  assign head_last = head[CX_W+1];

  // Ready comes only from registered state, so no update_flag -> in_ready path.
  assign in_ready  = ~full & ~pend_q;
  assign out_valid = ~empty;
  assign out_d     = head[CX_W];
  assign out_cx    = head[CX_W-1:0];

  assign push = in_valid & in_ready;
  assign pop  = update_flag & ~empty;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    if (push) wp_d = wp_q + PW'(1);
    if (pop)  rp_d = rp_q + PW'(1);
    if (push & ~pop)      level_d = level_q + LW'(1);
    else if (~push & pop) level_d = level_q - LW'(1);
    // Pushes are blocked while pending, so set and clear never collide.
    pend_d  = (pend_q & ~(pop & head_last)) | (push & in_last);
    flush_d = pop & head_last;
    af_d    = (level_d >= LW'(AF_LEVEL));
    eu_d    = eu_q | (update_flag & empty);
    eo_d    = eo_q | (in_valid & full & ~pend_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      pend_q  <= 1'b0;
      flush_q <= 1'b0;
      af_q    <= 1'b0;
      eu_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      af_q    <= af_d;
      eu_q    <= eu_d;
      eo_q    <= eo_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {in_last, in_d, in_cx};
  end

  assign flush_req     = flush_q;
  assign level         = level_q;
  assign almost_full   = af_q;
  assign err_underflow = eu_q;
  assign err_overflow  = eo_q;

endmodule
